// File: rtl/zxuno_regbus_pkg.sv
// zxuno_regbus_pkg: shared port addresses and write-FSM encoding for the ZXUNO register bus
package zxuno_regbus_pkg;

    localparam logic [15:0] ZXUNOADDR_DEFAULT = 16'hFC3B;
    localparam logic [15:0] ZXUNODATA_DEFAULT = 16'hFD3B;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        DONE
    } wr_state_t;

endpackage

// File: rtl/io_strobe_qualifier.sv
// io_strobe_qualifier: 2-sample history of one raw I/O decode, giving a glitch-filtered level and its rising edge
module io_strobe_qualifier (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_qual,
    output logic o_held,
    output logic o_rise
);

    logic [1:0] r_hist;
    logic       r_qual_d;

    // shift the raw decode into the history and remember last cycle's qualified level
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hist   <= 2'b00;
            r_qual_d <= 1'b0;
        end else begin
            r_hist   <= {r_hist[0], i_raw};
            r_qual_d <= o_qual;
        end
    end

    assign o_qual = &r_hist;
    assign o_held = r_hist[1];
    assign o_rise = o_qual & ~r_qual_d;

endmodule

// File: rtl/zxuno_regbus_master.sv
// zxuno_regbus_master: decodes Z80 index/data port cycles into ZXUNO register bus strobes
module zxuno_regbus_master
    import zxuno_regbus_pkg::*;
#(
    parameter logic [15:0] ZXUNOADDR = ZXUNOADDR_DEFAULT,
    parameter logic [15:0] ZXUNODATA = ZXUNODATA_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] a,
    input  logic        iorq_n,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic [7:0]  din,
    output logic [7:0]  dout,
    output logic        oe_n,
    output logic [7:0]  zxuno_addr,
    output logic        zxuno_regrd,
    output logic        zxuno_regwr,
    output logic        zxuno_rdpulse
);

    logic      w_wa, w_wd, w_ra, w_rd, w_wr_any;
    logic      w_wa_qual, w_wa_held, w_wa_rise;
    logic      w_wd_qual, w_wd_held, w_wd_rise;
    logic      w_ra_qual, w_ra_held, w_ra_rise;
    logic      w_rd_qual, w_rd_held, w_rd_rise;
    logic      w_act, w_regrd_nx, w_unused;
    wr_state_t r_state, w_state_nx;
    logic [7:0] r_addr, r_dout;
    logic      r_regrd, r_regwr, r_rdpulse, r_oe_n;

    assign w_wa     = ~iorq_n & ~wr_n & (a == ZXUNOADDR);
    assign w_wd     = ~iorq_n & ~wr_n & (a == ZXUNODATA);
    assign w_ra     = ~iorq_n & ~rd_n & (a == ZXUNOADDR);
    assign w_rd     = ~iorq_n & ~rd_n & (a == ZXUNODATA);
    assign w_wr_any = w_wa | w_wd;

    io_strobe_qualifier u_q_wa (.clk(clk), .rst(rst), .i_raw(w_wa), .o_qual(w_wa_qual), .o_held(w_wa_held), .o_rise(w_wa_rise));
    io_strobe_qualifier u_q_wd (.clk(clk), .rst(rst), .i_raw(w_wd), .o_qual(w_wd_qual), .o_held(w_wd_held), .o_rise(w_wd_rise));
    io_strobe_qualifier u_q_ra (.clk(clk), .rst(rst), .i_raw(w_ra), .o_qual(w_ra_qual), .o_held(w_ra_held), .o_rise(w_ra_rise));
    io_strobe_qualifier u_q_rd (.clk(clk), .rst(rst), .i_raw(w_rd), .o_qual(w_rd_qual), .o_held(w_rd_held), .o_rise(w_rd_rise));

    // write sequencing is done on the raw decode so din is sampled while WR is still low
    assign w_unused = ^{w_wa_qual, w_wa_held, w_wa_rise, w_wd_qual, w_wd_held, w_wd_rise,
                        w_ra_held, w_ra_rise, w_rd_qual};

    // write FSM state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nx;
    end

    // arm on first sample, act on the second, then wait for the strobe to end
    always_comb begin
        w_state_nx = w_wr_any ? ((r_state == IDLE) ? ARMED : DONE) : IDLE;
    end

    // the action happens exactly once, on the ARMED -> DONE transition
    always_comb begin
        w_act = (r_state == ARMED) & w_wr_any;
    end

    // regrd rises on the qualified edge and falls two samples after the strobe ends
    assign w_regrd_nx = r_regrd ? w_rd_held : w_rd_rise;

    // index register, strobes and readback
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr    <= 8'h00;
            r_dout    <= 8'h00;
            r_regwr   <= 1'b0;
            r_regrd   <= 1'b0;
            r_rdpulse <= 1'b0;
            r_oe_n    <= 1'b1;
        end else begin
            if (w_act & w_wa) r_addr <= din;
            r_dout    <= r_addr;
            r_regwr   <= w_act & w_wd;
            r_regrd   <= w_regrd_nx;
            r_rdpulse <= w_regrd_nx & ~r_regrd;
            r_oe_n    <= ~w_ra_qual;
        end
    end

    assign zxuno_addr    = r_addr;
    assign dout          = r_dout;
    assign oe_n          = r_oe_n;
    assign zxuno_regwr   = r_regwr;
    assign zxuno_regrd   = r_regrd;
    assign zxuno_rdpulse = r_rdpulse;

endmodule

// File: tb/tb_zxuno_regbus_master.sv
// tb_zxuno_regbus_master: cycle-level model comparison plus directed Z80 I/O scenarios
module tb_zxuno_regbus_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] a = 16'h0000;
    logic        iorq_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1;
    logic [7:0]  din = 8'h00;
    logic [7:0]  dout, zxuno_addr;
    logic        oe_n, zxuno_regrd, zxuno_regwr, zxuno_rdpulse;

    int n_cmp = 0, n_bad = 0;
    int cnt_regwr = 0, cnt_regrd = 0, cnt_rdpulse = 0, cnt_oe = 0;
    logic [7:0] din_at_regwr = 8'h00, dout_at_oe = 8'h00;

    // model state: sample histories and run lengths of the raw decodes
    logic [7:0] m_addr = 8'h00;
    int  w_run = 0, rd_run1 = 0, rd_run2 = 0;
    bit  rd_p1 = 0, rd_p2 = 0, ra_p1 = 0, ra_p2 = 0, e_regrd_prev = 0;
    logic [7:0] e_dout, e_addr;
    bit  e_oe_n, e_regwr, e_regrd, e_rdpulse;

    zxuno_regbus_master dut (
        .clk(clk), .rst(rst), .a(a), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
        .din(din), .dout(dout), .oe_n(oe_n), .zxuno_addr(zxuno_addr),
        .zxuno_regrd(zxuno_regrd), .zxuno_regwr(zxuno_regwr), .zxuno_rdpulse(zxuno_rdpulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // model: a write acts when its run of high samples reaches 2; reads/readback follow sample history
    always @(posedge clk) begin
        bit w, wa, wd, ra, rd;
        int run_now;
        w  = !iorq_n && !wr_n && (a == 16'hFC3B || a == 16'hFD3B);
        wa = !iorq_n && !wr_n && a == 16'hFC3B;
        wd = !iorq_n && !wr_n && a == 16'hFD3B;
        ra = !iorq_n && !rd_n && a == 16'hFC3B;
        rd = !iorq_n && !rd_n && a == 16'hFD3B;
        if (rst) begin
            m_addr = 8'h00; w_run = 0;
            rd_p1 = 0; rd_p2 = 0; rd_run1 = 0; rd_run2 = 0; ra_p1 = 0; ra_p2 = 0;
            e_dout = 8'h00; e_oe_n = 1; e_regwr = 0; e_regrd = 0; e_rdpulse = 0;
        end else begin
            e_dout  = m_addr;
            w_run   = w ? w_run + 1 : 0;
            e_regwr = (w_run == 2) && wd;
            if (w_run == 2 && wa) m_addr = din;
            e_oe_n    = !(ra_p1 && ra_p2);
            e_regrd   = rd_p2 && (rd_p1 || rd_run2 >= 2);
            e_rdpulse = e_regrd && !e_regrd_prev;
            run_now = rd ? rd_run1 + 1 : 0;
            rd_p2 = rd_p1; rd_run2 = rd_run1; rd_p1 = rd; rd_run1 = run_now;
            ra_p2 = ra_p1; ra_p1 = ra;
        end
        e_addr = m_addr;
        e_regrd_prev = e_regrd;
        #1;
        chk("addr", {8'h00, zxuno_addr}, {8'h00, e_addr});
        chk("dout", {8'h00, dout}, {8'h00, e_dout});
        chk("oe_n", {15'h0, oe_n}, {15'h0, e_oe_n});
        chk("regwr", {15'h0, zxuno_regwr}, {15'h0, e_regwr});
        chk("regrd", {15'h0, zxuno_regrd}, {15'h0, e_regrd});
        chk("rdpulse", {15'h0, zxuno_rdpulse}, {15'h0, e_rdpulse});
        if (zxuno_regwr) begin cnt_regwr++; din_at_regwr = din; end
        if (zxuno_regrd) cnt_regrd++;
        if (zxuno_rdpulse) cnt_rdpulse++;
        if (!oe_n) begin cnt_oe++; dout_at_oe = dout; end
    end

    task automatic clr();
        cnt_regwr = 0; cnt_regrd = 0; cnt_rdpulse = 0; cnt_oe = 0;
    endtask

    task automatic io(input logic [15:0] ad, input bit wr, input logic [7:0] d, input int n);
        @(negedge clk);
        a = ad; din = d; iorq_n = 1'b0;
        if (wr) wr_n = 1'b0; else rd_n = 1'b0;
        repeat (n) @(negedge clk);
        iorq_n = 1'b1; wr_n = 1'b1; rd_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_addr", {8'h00, zxuno_addr}, 16'h0000);
        chk("rst_oe_n", {15'h0, oe_n}, 16'h0001);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        clr();
        io(16'hFC3B, 1, 8'h0B, 5);
        chk("idx_wr_addr", {8'h00, zxuno_addr}, 16'h000B);
        chk("idx_wr_noregwr", cnt_regwr[15:0], 16'd0);

        clr();
        io(16'hFD3B, 1, 8'hA5, 8);
        chk("data_wr_pulses", cnt_regwr[15:0], 16'd1);
        chk("data_wr_din", {8'h00, din_at_regwr}, 16'h00A5);
        chk("data_wr_addr", {8'h00, zxuno_addr}, 16'h000B);

        clr();
        io(16'hFD3B, 1, 8'h77, 1);
        chk("glitch_pulses", cnt_regwr[15:0], 16'd0);
        chk("glitch_addr", {8'h00, zxuno_addr}, 16'h000B);

        clr();
        io(16'hFD3B, 0, 8'h00, 6);
        chk("rd_len", cnt_regrd[15:0], 16'd6);
        chk("rd_pulses", cnt_rdpulse[15:0], 16'd1);
        chk("rd_oe", cnt_oe[15:0], 16'd0);

        io(16'hFC3B, 1, 8'h3C, 4);
        clr();
        io(16'hFC3B, 0, 8'h00, 5);
        chk("idx_rd_oe_len", cnt_oe[15:0], 16'd4);
        chk("idx_rd_dout", {8'h00, dout_at_oe}, 16'h003C);
        chk("idx_rd_oe_after", {15'h0, oe_n}, 16'h0001);

        clr();
        @(negedge clk);
        a = 16'hFC3B; din = 8'h11; iorq_n = 1'b0; wr_n = 1'b0;
        repeat (3) @(negedge clk);
        a = 16'hFD3B; din = 8'h22;
        repeat (3) @(negedge clk);
        iorq_n = 1'b1; wr_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("switch_addr", {8'h00, zxuno_addr}, 16'h0011);
        chk("switch_noregwr", cnt_regwr[15:0], 16'd0);

        clr();
        @(negedge clk);
        a = 16'hFD3B; din = 8'h5A; iorq_n = 1'b0; wr_n = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_regwr", {15'h0, zxuno_regwr}, 16'h0000);
        chk("mid_rst_addr", {8'h00, zxuno_addr}, 16'h0000);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        iorq_n = 1'b1; wr_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("mid_rst_pulses", cnt_regwr[15:0], 16'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
